alu: RTL and testbench

// - 32-bit integer ALU for the RV32I single-cycle datapath. Computes add, sub, logic,

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_addsub.sv | 28 ++
 rtl/alu.sv | 80 ++++++++
 tb/tb_alu.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 4-bit operation encoding used by the ALU and
// by the control decoder that drives ALUControl.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    // True for every operation that needs the subtractor (SUB and both compares).
    function automatic logic needs_sub(input logic [3:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared 33-bit adder/subtractor. Subtraction is formed as a + ~b + 1 so the
// carry out reads as "no borrow" and the compare ops can reuse it.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    input  logic                 sub,
    output logic [ALU_WIDTH-1:0] sum,
    output logic                 carry,
    output logic                 overflow
);

    logic [ALU_WIDTH-1:0] b_eff;
    logic [ALU_WIDTH:0]   wide_sum;

    // Invert B for subtraction, add with carry-in, and derive signed overflow
    // from the operand signs actually fed to the adder.
    always_comb begin
        b_eff    = sub ? ~b : b;
        wide_sum = {1'b0, a} + {1'b0, b_eff} + {{ALU_WIDTH{1'b0}}, sub};
        sum      = wide_sum[ALU_WIDTH-1:0];
        carry    = wide_sum[ALU_WIDTH];
        overflow = (a[ALU_WIDTH-1] == b_eff[ALU_WIDTH-1]) &&
                   (wide_sum[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// RV32I ALU: combinational operation select and flag generation, with all
// outputs registered for a one-cycle latency.
module alu
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ALU_WIDTH-1:0] A,
    input  logic [ALU_WIDTH-1:0] B,
    input  logic [3:0]           ALUControl,
    output logic [ALU_WIDTH-1:0] Result,
    output logic                 Z_flag,
    output logic                 N_flag,
    output logic                 C_flag,
    output logic                 V_flag
);

    logic [ALU_WIDTH-1:0] as_sum;
    logic                 as_carry;
    logic                 as_overflow;
    logic                 do_sub;
    logic [4:0]           shamt;

    logic [ALU_WIDTH-1:0] result_next;
    logic                 c_next;
    logic                 v_next;

    assign do_sub = needs_sub(ALUControl);
    assign shamt  = B[4:0];

    alu_addsub u_addsub (
        .a        (A),
        .b        (B),
        .sub      (do_sub),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_overflow)
    );

    // Select the result for the current opcode; only ADD/SUB report carry and overflow.
    always_comb begin
        result_next = '0;
        c_next      = 1'b0;
        v_next      = 1'b0;
        case (ALUControl)
            ALU_ADD, ALU_SUB: begin
                result_next = as_sum;
                c_next      = as_carry;
                v_next      = as_overflow;
            end
            ALU_AND:  result_next = A & B;
            ALU_OR:   result_next = A | B;
            ALU_XOR:  result_next = A ^ B;
            ALU_SLL:  result_next = A << shamt;
            ALU_SRL:  result_next = A >> shamt;
            ALU_SRA:  result_next = $unsigned($signed(A) >>> shamt);
            ALU_SLT:  result_next = {{(ALU_WIDTH-1){1'b0}}, as_sum[ALU_WIDTH-1] ^ as_overflow};
            ALU_SLTU: result_next = {{(ALU_WIDTH-1){1'b0}}, ~as_carry};
            default:  result_next = '0;
        endcase
    end

    // Register result and flags every cycle; async reset shows a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result <= '0;
            Z_flag <= 1'b1;
            N_flag <= 1'b0;
            C_flag <= 1'b0;
            V_flag <= 1'b0;
        end else begin
            Result <= result_next;
            Z_flag <= (result_next == '0);
            N_flag <= result_next[ALU_WIDTH-1];
            C_flag <= c_next;
            V_flag <= v_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the ALU: directed vector table, reset sequences,
// and randomized operations compared against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic [31:0] Result;
    logic        Z_flag;
    logic        N_flag;
    logic        C_flag;
    logic        V_flag;

    int total;
    int bad;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic [3:0]  exp_zncv;
    } vec_t;

    localparam int NUM_VECS = 22;
    vec_t vecs [NUM_VECS];

    alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Result     (Result),
        .Z_flag     (Z_flag),
        .N_flag     (N_flag),
        .C_flag     (C_flag),
        .V_flag     (V_flag)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive operands half a cycle before the capturing edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUControl = op;
        A          = a;
        B          = b;
    endtask

    // Compare the registered outputs against expected result and ZNCV flags.
    task automatic checkOutput(input string name, input logic [31:0] exp_r, input logic [3:0] exp_zncv);
        logic [3:0] got_zncv;
        got_zncv = {Z_flag, N_flag, C_flag, V_flag};
        total++;
        if (Result !== exp_r || got_zncv !== exp_zncv) begin
            bad++;
            $display("[TB] FAIL %s: got R=%h ZNCV=%b, want R=%h ZNCV=%b",
                     name, Result, got_zncv, exp_r, exp_zncv);
        end
    endtask

    // Apply one operation and check it just after the next rising edge.
    task automatic runVector(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_zncv);
        applyStimulus(op, a, b);
        @(posedge clk);
        #1;
        checkOutput(name, exp_r, exp_zncv);
    endtask

    // Reference model built from the arithmetic meaning of each operation.
    task automatic refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output logic [3:0] zncv);
        longint      sa;
        longint      sb;
        longint      exact;
        int          sh;
        logic        c;
        logic        v;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        sh    = int'(b % 32);
        c     = 1'b0;
        v     = 1'b0;
        exact = 0;
        case (op)
            4'b0000: begin
                r     = a + b;
                c     = (longint'(a) + longint'(b)) >= 64'sd4294967296;
                exact = sa + sb;
                v     = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
            end
            4'b0001: begin
                r     = a - b;
                c     = (a >= b);
                exact = sa - sb;
                v     = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
            end
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0110: r = a ^ b;
            4'b0100: r = 32'(longint'(a) * (64'sd1 << sh));
            4'b0111: r = 32'(longint'(a) / (64'sd1 << sh));
            4'b1111: begin
                exact = sa;
                for (int i = 0; i < sh; i++)
                    exact = (exact < 0) ? -((-exact + 1) / 2) : exact / 2;
                r = 32'(exact);
            end
            4'b0101: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        zncv = {(r == 32'd0), r[31], c, v};
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        logic [31:0] mr;
        logic [3:0]  mf;

        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        A          = 32'h7FFF_FFFF;
        B          = 32'h0000_0001;
        ALUControl = ALU_ADD;

        vecs[0]  = '{"add_5_3",        ALU_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 4'b0000};
        vecs[1]  = '{"add_0_0",        ALU_ADD,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b1000};
        vecs[2]  = '{"sub_ffff_0",     ALU_SUB,  32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0110};
        vecs[3]  = '{"sub_5_a",        ALU_SUB,  32'h0000_0005, 32'h0000_000A, 32'hFFFF_FFFB, 4'b0100};
        vecs[4]  = '{"and_f_f0",       ALU_AND,  32'h0000_000F, 32'h0000_00F0, 32'h0000_0000, 4'b1000};
        vecs[5]  = '{"or_f_f0",        ALU_OR,   32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000};
        vecs[6]  = '{"xor_ff_f",       ALU_XOR,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 4'b0000};
        vecs[7]  = '{"sll_1_2",        ALU_SLL,  32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 4'b0000};
        vecs[8]  = '{"srl_10_2",       ALU_SRL,  32'h0000_0010, 32'h0000_0002, 32'h0000_0004, 4'b0000};
        vecs[9]  = '{"sra_neg_2",      ALU_SRA,  32'h8000_0010, 32'h0000_0002, 32'hE000_0004, 4'b0100};
        vecs[10] = '{"slt_5_10",       ALU_SLT,  32'h0000_0005, 32'h0000_0010, 32'h0000_0001, 4'b0000};
        vecs[11] = '{"sltu_5_10",      ALU_SLTU, 32'h0000_0005, 32'h0000_0010, 32'h0000_0001, 4'b0000};
        vecs[12] = '{"slt_m1_1",       ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000};
        vecs[13] = '{"sltu_m1_1",      ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000};
        vecs[14] = '{"add_ovf_pos",    ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101};
        vecs[15] = '{"add_wrap",       ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010};
        vecs[16] = '{"sub_ovf_neg",    ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
        vecs[17] = '{"sub_equal",      ALU_SUB,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 4'b1010};
        vecs[18] = '{"sll_shamt0",     ALU_SLL,  32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0100};
        vecs[19] = '{"sra_shamt0",     ALU_SRA,  32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001, 4'b0100};
        vecs[20] = '{"illegal_1001",   4'b1001,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000};
        vecs[21] = '{"illegal_1010",   4'b1010,  32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000};

        // Reset is held across clock edges even with live operands.
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 32'h0, 4'b1000);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NUM_VECS; i++)
            runVector(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_zncv);

        // Asynchronous reset mid-run clears outputs without waiting for a clock.
        runVector("pre_reset_load", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 32'h0, 4'b1000);

        // First edge after release loads whatever is on the inputs.
        applyStimulus(ALU_SUB, 32'h0000_0005, 32'h0000_000A);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_first_edge", 32'hFFFF_FFFB, 4'b0100);

        // Randomized operations with a bias toward corner operand values.
        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) ra = (ra[0]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            if ($urandom_range(0, 3) == 0) rb = (rb[1]) ? 32'hFFFF_FFFF : {27'h0, rb[4:0]};
            if ($urandom_range(0, 7) == 0) rb = ra;
            refModel(rop, ra, rb, mr, mf);
            runVector($sformatf("rand_%0d_op%0h", i, rop), rop, ra, rb, mr, mf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
